// File: rtl/regfile_sb.sv
// regfile_sb: 32x32 register file with write-through bypass and load scoreboard
module regfile_sb (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr_a,
  input  logic [4:0]  raddr_b,
  output logic [31:0] rdata_a,
  output logic [31:0] rdata_b,
  input  logic        mark_en,
  input  logic [4:0]  mark_addr,
  input  logic        flush,
  output logic        busy_a,
  output logic        busy_b,
  output logic [5:0]  pending_cnt,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data
);
  logic [31:0] regs [32];
  logic [31:0] pending;
  logic [31:0] pending_nxt;
  logic        do_wr;
  logic        do_mk;
  logic        inc;
  logic        dec;

  function automatic logic [31:0] rd(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : (we && waddr == a) ? wdata : regs[a];
  endfunction

  function automatic logic bsy(input logic [4:0] a);
    return a != 5'd0 && pending[a] && !(we && waddr == a);
  endfunction

  assign do_wr   = we && waddr != 5'd0;
  assign do_mk   = mark_en && mark_addr != 5'd0 && !flush;
  assign inc     = do_mk && !pending[mark_addr];
  assign dec     = do_wr && pending[waddr] && !(do_mk && mark_addr == waddr);
  assign rdata_a = rd(raddr_a);
  assign rdata_b = rd(raddr_b);
  assign busy_a  = bsy(raddr_a);
  assign busy_b  = bsy(raddr_b);

  // next pending vector: clear on writeback, mark wins over clear, flush clears all
  always_comb begin
    pending_nxt = pending;
    if (do_wr) pending_nxt[waddr] = 1'b0;
    if (do_mk) pending_nxt[mark_addr] = 1'b1;
    if (flush) pending_nxt = '0;
    pending_nxt[0] = 1'b0;
  end

  // register storage; writeback is never stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (do_wr) begin
      regs[waddr] <= wdata;
    end
  end

  // scoreboard vector and its incrementally tracked population count
  always_ff @(posedge clk) begin
    pending     <= rst ? '0 : pending_nxt;
    pending_cnt <= (rst || flush) ? 6'd0 : pending_cnt + 6'(inc) - 6'(dec);
  end

  // debug port sees the same bypassed value as a read port, one cycle later
  always_ff @(posedge clk) begin
    dbg_data <= rst ? 32'd0 : rd(dbg_addr);
  end
endmodule
